// File: rtl/mem_dbus_ctrl_pkg.sv
// Shared types for the memory-stage data-bus controller: bus sizes, opcodes,
// dbus request/response records and the controller state encoding.
package mem_dbus_ctrl_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9,
        SWL = 4'd10,
        SWR = 4'd11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    // Unaligned-word ops always move a full word on the bus.
    function automatic logic is_partial_word_op(input op_t op);
        return (op == LWL) || (op == LWR) || (op == SWL) || (op == SWR);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load-data aligner: picks, extends or merges bytes of the raw
// bus word according to the opcode and byte offset.
module mem_load_align
    import mem_dbus_ctrl_pkg::*;
(
    input  op_t         i_op,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_raw,
    input  logic [31:0] i_rt_old,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shr;
    logic [4:0]  w_shl;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // 3 - offset equals the bitwise inverse of a 2-bit offset.
    assign w_shr     = {i_offset, 3'b000};
    assign w_shl     = {~i_offset, 3'b000};
    assign w_shifted = i_raw >> w_shr;
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_offset[1] ? i_raw[31:16] : i_raw[15:0];

    always_comb begin
        o_rdata = '0;
        case (i_op)
            LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
            LBU: o_rdata = {24'h0, w_byte};
            LH:  o_rdata = {{16{w_half[15]}}, w_half};
            LHU: o_rdata = {16'h0, w_half};
            LW:  o_rdata = i_raw;
            LWL: o_rdata = (i_raw << w_shl) | (i_rt_old & ~(32'hFFFF_FFFF << w_shl));
            LWR: o_rdata = w_shifted | (i_rt_old & ~(32'hFFFF_FFFF >> w_shr));
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_dbus_ctrl.sv
// Memory-stage dbus controller: one bus transaction per load/store, stalls the
// pipe until data_ok. Optional stall counter enabled by MEM_DBUS_PERF_EN.
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    input  logic              req_write,
    input  op_t               req_op,
    input  msize_t            req_msize,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_rt_old,
    input  logic [3:0]        strobe_in,
    input  logic              advance,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output msize_t            dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              stall,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              exc_adel,
    output logic              exc_ades
`ifdef MEM_DBUS_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    state_t      r_state;
    state_t      w_next;
    dbus_req_t   r_req;
    op_t         r_op;
    logic [1:0]  r_off;
    logic [31:0] r_rt_old;
    logic        r_write;
    logic [31:0] r_rdata;

    dbus_resp_t  w_resp;
    logic        w_idle_req;
    logic        w_load_mis;
    logic        w_store_mis;
    logic        w_exc;
    logic        w_start;
    logic        w_data_done;
    logic [4:0]  w_shl;
    logic [4:0]  w_shr;
    logic [31:0] w_store_data;
    logic [31:0] w_align;
    dbus_req_t   w_new_req;

    assign w_resp = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};

    // Exceptions and stall are gated by resetn so every output reads 0 while held in reset.
    assign w_idle_req  = resetn && req_valid && (r_state == IDLE);
    assign w_load_mis  = (((req_op == LH) || (req_op == LHU)) && req_addr[0])
                       || ((req_op == LW) && (req_addr[1:0] != 2'b00));
    assign w_store_mis = (req_msize != MSIZE1) && !is_partial_word_op(req_op)
                       && (strobe_in == 4'b0000);
    assign exc_adel    = w_idle_req && !req_write && w_load_mis;
    assign exc_ades    = w_idle_req && req_write && w_store_mis;
    assign w_exc       = exc_adel || exc_ades;
    assign w_start     = w_idle_req && !w_exc;

    assign w_shl        = {req_addr[1:0], 3'b000};
    assign w_shr        = {~req_addr[1:0], 3'b000};
    assign w_store_data = !req_write     ? 32'h0 :
                          (req_op == SWL) ? (req_wdata >> w_shr) : (req_wdata << w_shl);

    assign w_new_req.addr   = is_partial_word_op(req_op) ? {req_addr[31:2], 2'b00} : req_addr;
    assign w_new_req.size   = is_partial_word_op(req_op) ? MSIZE4 : req_msize;
    assign w_new_req.strobe = req_write ? strobe_in : 4'b0000;
    assign w_new_req.data   = w_store_data;

    assign w_data_done = ((r_state == ADDR) && w_resp.addr_ok && w_resp.data_ok)
                       || ((r_state == DATA) && w_resp.data_ok);

    mem_load_align u_load_align (
        .i_op     (r_op),
        .i_offset (r_off),
        .i_raw    (w_resp.data),
        .i_rt_old (r_rt_old),
        .o_rdata  (w_align)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = ADDR;
            ADDR: if (w_resp.addr_ok) w_next = w_resp.data_ok ? DONE : DATA;
            DATA: if (w_resp.data_ok) w_next = DONE;
            DONE: if (advance) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request fields are frozen at issue so the bus sees them stable until addr_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_req    <= '0;
            r_op     <= LB;
            r_off    <= 2'b00;
            r_rt_old <= 32'h0;
            r_write  <= 1'b0;
        end else if (w_start) begin
            r_req    <= w_new_req;
            r_op     <= req_op;
            r_off    <= req_addr[1:0];
            r_rt_old <= req_rt_old;
            r_write  <= req_write;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 32'h0;
        end else if (w_data_done) begin
            r_rdata <= r_write ? 32'h0 : w_align;
        end
    end

    always_comb begin
        dreq_valid  = 1'b0;
        rdata_valid = 1'b0;
        rdata       = '0;
        stall       = 1'b0;
        dreq_addr   = r_req.addr;
        dreq_size   = r_req.size;
        dreq_strobe = r_req.strobe;
        dreq_data   = r_req.data;
        if (r_state == ADDR) dreq_valid = 1'b1;
        if (r_state == DONE) begin
            rdata_valid = 1'b1;
            rdata       = r_rdata;
        end
        if (resetn && req_valid && (r_state != DONE) && !w_exc) stall = 1'b1;
    end

`ifdef MEM_DBUS_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_cnt <= 32'h0;
        end else if (stall) begin
            r_perf_cnt <= r_perf_cnt + 32'h1;
        end
    end

    assign perf_stall_cnt = r_perf_cnt;
`endif

    // data_ok before the address phase is accepted breaks the dbus protocol.
    a_no_early_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        !((r_state == ADDR) && dresp_data_ok && !dresp_addr_ok));

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed, table-driven bench for mem_dbus_ctrl; perf counter checks are
// compiled in when MEM_DBUS_PERF_EN is defined.
module tb_mem_dbus_ctrl;
    import mem_dbus_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_write, advance;
    op_t         req_op;
    msize_t      req_msize;
    logic [31:0] req_addr, req_wdata, req_rt_old;
    logic [3:0]  strobe_in;
    logic        dreq_valid;
    logic [31:0] dreq_addr, dreq_data;
    msize_t      dreq_size;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        stall, rdata_valid, exc_adel, exc_ades;
    logic [31:0] rdata;
`ifdef MEM_DBUS_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    mem_dbus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_op        (req_op),
        .req_msize     (req_msize),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rt_old    (req_rt_old),
        .strobe_in     (strobe_in),
        .advance       (advance),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .stall         (stall),
        .rdata_valid   (rdata_valid),
        .rdata         (rdata),
        .exc_adel      (exc_adel),
        .exc_ades      (exc_ades)
`ifdef MEM_DBUS_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    typedef struct {
        op_t         op;
        msize_t      msize;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rtOld;
        logic [3:0]  strobe;
        logic [31:0] bus;
        logic [31:0] expAddr;
        msize_t      expSize;
        logic [3:0]  expStrobe;
        logic [31:0] expData;
        logic [31:0] expRdata;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mkVec(op_t op, msize_t ms, logic [31:0] addr, logic [31:0] wdata,
                                   logic [31:0] rtOld, logic [3:0] strobe, logic [31:0] bus,
                                   logic [31:0] expAddr, msize_t expSize, logic [3:0] expStrobe,
                                   logic [31:0] expData, logic [31:0] expRdata);
        vec_t v;
        v.op = op; v.msize = ms; v.addr = addr; v.wdata = wdata; v.rtOld = rtOld;
        v.strobe = strobe; v.bus = bus; v.expAddr = expAddr; v.expSize = expSize;
        v.expStrobe = expStrobe; v.expData = expData; v.expRdata = expRdata;
        return v;
    endfunction

    function automatic logic isStore(op_t op);
        return op inside {SB, SH, SW, SWL, SWR};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic driveReq(input op_t op, input msize_t ms, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rtOld, input logic [3:0] strobe);
        req_valid  = 1'b1;
        req_write  = isStore(op);
        req_op     = op;
        req_msize  = ms;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rt_old = rtOld;
        strobe_in  = strobe;
    endtask

    // One full transaction with addr_ok and data_ok together on the first address cycle.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(posedge clk); #1;
        driveReq(v.op, v.msize, v.addr, v.wdata, v.rtOld, v.strobe);
        @(negedge clk);
        checkOutput({tag, " idle stall"}, 32'(stall), 32'd1);
        checkOutput({tag, " idle dreq_valid"}, 32'(dreq_valid), 32'd0);
        @(posedge clk); #1;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = v.bus;
        @(negedge clk);
        checkOutput({tag, " dreq_valid"}, 32'(dreq_valid), 32'd1);
        checkOutput({tag, " dreq_addr"}, dreq_addr, v.expAddr);
        checkOutput({tag, " dreq_size"}, 32'(dreq_size), 32'(v.expSize));
        checkOutput({tag, " dreq_strobe"}, 32'(dreq_strobe), 32'(v.expStrobe));
        checkOutput({tag, " dreq_data"}, dreq_data, v.expData);
        checkOutput({tag, " addr stall"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
        @(negedge clk);
        checkOutput({tag, " rdata_valid"}, 32'(rdata_valid), 32'd1);
        checkOutput({tag, " rdata"}, rdata, v.expRdata);
        checkOutput({tag, " done stall"}, 32'(stall), 32'd0);
        advance = 1'b1;
        @(posedge clk); #1;
        advance = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, " back idle"}, 32'(rdata_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = mkVec(LW,  MSIZE4, 32'h1000, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF, 32'h1000, MSIZE4, 4'h0, 32'h0, 32'hDEADBEEF);
        vecs[1]  = mkVec(LB,  MSIZE1, 32'h3001, 32'h0, 32'h0, 4'h0, 32'h00008000, 32'h3001, MSIZE1, 4'h0, 32'h0, 32'hFFFFFF80);
        vecs[2]  = mkVec(LBU, MSIZE1, 32'h3001, 32'h0, 32'h0, 4'h0, 32'h00008000, 32'h3001, MSIZE1, 4'h0, 32'h0, 32'h00000080);
        vecs[3]  = mkVec(LWL, MSIZE2, 32'h4001, 32'h0, 32'hAABBCCDD, 4'h0, 32'h11223344, 32'h4000, MSIZE4, 4'h0, 32'h0, 32'h3344CCDD);
        vecs[4]  = mkVec(LWR, MSIZE2, 32'h4001, 32'h0, 32'hAABBCCDD, 4'h0, 32'h11223344, 32'h4000, MSIZE4, 4'h0, 32'h0, 32'hAA112233);
        vecs[5]  = mkVec(LH,  MSIZE2, 32'h3002, 32'h0, 32'h0, 4'h0, 32'h80011234, 32'h3002, MSIZE2, 4'h0, 32'h0, 32'hFFFF8001);
        vecs[6]  = mkVec(LHU, MSIZE2, 32'h3002, 32'h0, 32'h0, 4'h0, 32'h80011234, 32'h3002, MSIZE2, 4'h0, 32'h0, 32'h00008001);
        vecs[7]  = mkVec(SW,  MSIZE4, 32'h6000, 32'h12345678, 32'h0, 4'hF, 32'h0, 32'h6000, MSIZE4, 4'hF, 32'h12345678, 32'h0);
        vecs[8]  = mkVec(SH,  MSIZE2, 32'h6002, 32'h0000BEEF, 32'h0, 4'hC, 32'h0, 32'h6002, MSIZE2, 4'hC, 32'hBEEF0000, 32'h0);
        vecs[9]  = mkVec(SWL, MSIZE4, 32'h6001, 32'hAABBCCDD, 32'h0, 4'h3, 32'h0, 32'h6000, MSIZE4, 4'h3, 32'h0000AABB, 32'h0);
        vecs[10] = mkVec(SWR, MSIZE4, 32'h6002, 32'hAABBCCDD, 32'h0, 4'hC, 32'h0, 32'h6000, MSIZE4, 4'hC, 32'hCCDD0000, 32'h0);
        vecs[11] = mkVec(LWL, MSIZE4, 32'h4003, 32'h0, 32'hAABBCCDD, 4'h0, 32'h11223344, 32'h4000, MSIZE4, 4'h0, 32'h0, 32'h11223344);
        vecs[12] = mkVec(LWR, MSIZE4, 32'h4000, 32'h0, 32'hAABBCCDD, 4'h0, 32'h11223344, 32'h4000, MSIZE4, 4'h0, 32'h0, 32'h11223344);
        vecs[13] = mkVec(LB,  MSIZE1, 32'h3003, 32'h0, 32'h0, 4'h0, 32'h7F000000, 32'h3003, MSIZE1, 4'h0, 32'h0, 32'h0000007F);

        resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_op = LB; req_msize = MSIZE1;
        req_addr = 32'h0; req_wdata = 32'h0; req_rt_old = 32'h0; strobe_in = 4'h0; advance = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;
        #13;
        checkOutput("reset dreq_valid", 32'(dreq_valid), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset rdata_valid", 32'(rdata_valid), 32'd0);
        checkOutput("reset dreq_addr", dreq_addr, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        applyStimulus(vecs[0], "vec0");
`ifdef MEM_DBUS_PERF_EN
        checkOutput("perf after LW", perf_stall_cnt, 32'd2);
`endif
        for (int i = 1; i < 14; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // SB with addr_ok held off for three cycles and data_ok two cycles after it
        @(posedge clk); #1;
        driveReq(SB, MSIZE1, 32'h2003, 32'h000000AB, 32'h0, 4'b1000);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 3) dresp_addr_ok = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("sb wait%0d dreq_valid", c), 32'(dreq_valid), 32'd1);
            checkOutput($sformatf("sb wait%0d dreq_addr", c), dreq_addr, 32'h2003);
            checkOutput($sformatf("sb wait%0d dreq_data", c), dreq_data, 32'hAB000000);
            checkOutput($sformatf("sb wait%0d dreq_strobe", c), 32'(dreq_strobe), 32'b1000);
            checkOutput($sformatf("sb wait%0d stall", c), 32'(stall), 32'd1);
        end
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        @(negedge clk);
        checkOutput("sb data1 dreq_valid", 32'(dreq_valid), 32'd0);
        checkOutput("sb data1 stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        dresp_data_ok = 1'b1;
        @(negedge clk);
        checkOutput("sb data2 rdata_valid", 32'(rdata_valid), 32'd0);
        @(posedge clk); #1;
        dresp_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("sb done rdata_valid", 32'(rdata_valid), 32'd1);
        checkOutput("sb done rdata", rdata, 32'h0);
        checkOutput("sb done stall", 32'(stall), 32'd0);
        advance = 1'b1;
        @(posedge clk); #1;
        advance = 1'b0; req_valid = 1'b0;

        // Misaligned accesses: exception flagged, no bus request, no stall
        @(posedge clk); #1;
        driveReq(LW, MSIZE4, 32'h5002, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("lw mis exc_adel", 32'(exc_adel), 32'd1);
        checkOutput("lw mis exc_ades", 32'(exc_ades), 32'd0);
        checkOutput("lw mis stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lw mis no dreq", 32'(dreq_valid), 32'd0);
        checkOutput("lw mis still adel", 32'(exc_adel), 32'd1);
        @(posedge clk); #1;
        driveReq(SH, MSIZE2, 32'h5001, 32'h1234, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("sh mis exc_ades", 32'(exc_ades), 32'd1);
        checkOutput("sh mis exc_adel", 32'(exc_adel), 32'd0);
        checkOutput("sh mis stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        driveReq(LH, MSIZE2, 32'h5001, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("lh mis exc_adel", 32'(exc_adel), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Reset asserted while waiting in the data phase
        @(posedge clk); #1;
        driveReq(LW, MSIZE4, 32'h7000, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        dresp_addr_ok = 1'b1;
        @(posedge clk); #1;
        dresp_addr_ok = 1'b0;
        @(negedge clk);
        checkOutput("rst pre stall", 32'(stall), 32'd1);
        checkOutput("rst pre dreq_valid", 32'(dreq_valid), 32'd0);
        #1 resetn = 1'b0;
        #1;
        checkOutput("rst stall", 32'(stall), 32'd0);
        checkOutput("rst dreq_addr", dreq_addr, 32'h0);
        checkOutput("rst dreq_size", 32'(dreq_size), 32'(MSIZE1));
        checkOutput("rst rdata_valid", 32'(rdata_valid), 32'd0);
`ifdef MEM_DBUS_PERF_EN
        checkOutput("rst perf", perf_stall_cnt, 32'd0);
`endif
        req_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("post rst dreq_valid", 32'(dreq_valid), 32'd0);
        applyStimulus(vecs[1], "post rst");

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mem_dbus_ctrl.md
Name: mem_dbus_ctrl

Overview:
- Memory-stage data-bus controller that sits directly downstream of the store-strobe selector.
- Takes one memory-stage request per instruction, together with the 4-bit write strobe already computed for it, and drives a single dbus transaction (dreq/dresp, addr_ok/data_ok handshake).
- Stalls the pipeline until the transaction completes.
- Returns aligned, extended and merged load data (LB/LBU/LH/LHU/LW/LWL/LWR) to writeback.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  memory stage holds a load/store; held stable while stall=1
- req_write  in  1  1 = store, 0 = load
- req_op  in  op_t  instruction opcode (LB..SWR)
- req_msize  in  msize_t  MSIZE1/MSIZE2/MSIZE4
- req_addr  in  32  effective byte address
- req_wdata  in  32  rt value to be stored
- req_rt_old  in  32  current rt value, used for the LWL/LWR merge
- strobe_in  in  4  write strobe from the strobe selector; 0 on a misaligned store
- advance  in  1  pipeline accepts the result this cycle
- dreq_valid  out  1  bus request valid
- dreq_addr  out  32  bus address
- dreq_size  out  msize_t  bus size
- dreq_strobe  out  4  byte enables; 0 for loads
- dreq_data  out  32  lane-shifted store data
- dresp_addr_ok  in  1  address accepted
- dresp_data_ok  in  1  data phase done
- dresp_data  in  32  raw read word
- stall  out  1  memory stage must hold
- rdata_valid  out  1  result ready
- rdata  out  32  final load value
- exc_adel  out  1  misaligned load
- exc_ades  out  1  misaligned store

Behaviour:
- Reset: async on resetn low.
  - State goes to IDLE.
  - All outputs 0; captured registers 0.
  - A transaction in flight is abandoned. Bus-side recovery is the bus's responsibility, because the bus shares the same reset.
- States: IDLE, ADDR, DATA, DONE.
- IDLE with req_valid:
  - If misaligned, no request is issued. Misaligned means: load with LH/LHU and addr[0]≠0, or LW and addr[1:0]≠0; store with MSIZE2/MSIZE4 (excluding SWL/SWR) and strobe_in==0.
  - Misaligned case: exc_adel or exc_ades is driven combinationally that same cycle, stall=0, and the state stays IDLE.
  - Otherwise, the registered request fields are captured and the state moves to ADDR. stall=1.
- ADDR:
  - dreq_valid=1, with dreq_* driven from the captured registers and stable until addr_ok.
  - addr_ok and data_ok both high → DONE.
  - addr_ok alone → DATA.
- DATA: dreq_valid=0; data_ok → DONE. A data_ok arriving while in ADDR without addr_ok is ignored; it is a protocol violation and is flagged by an assertion.
- DONE:
  - rdata_valid=1, stall=0.
  - rdata is held from a register captured on the data_ok edge.
  - advance → IDLE; otherwise remain in DONE.
- stall = req_valid & state≠DONE & ~exception.
- Minimum latency: IDLE→ADDR→DONE, i.e. 2 cycles of stall.
- Bus address: dreq_addr = addr with [1:0] cleared for LWL/LWR/SWL/SWR, else addr.
- Bus size: dreq_size = MSIZE4 for LWL/LWR/SWL/SWR, else req_msize.
- Store data, with o = addr[1:0]:
  - SB/SH/SW/SWR: wdata << 8·o
  - SWL: wdata >> 8·(3−o)
- Load data, with w = dresp_data:
  - LB/LBU: byte o of w, sign-/zero-extended.
  - LH/LHU: half o[1] of w, extended.
  - LW: w.
  - LWL: bytes replaced from rt_old, giving (w << 8·(3−o)) | (rt_old & (2^(8·(3−o))−1)).
  - LWR: (w >> 8·o) | (rt_old & ~(2^32−1 >> 8·o)).
- Stores complete with rdata=0 and rdata_valid=1, so the pipeline flow is uniform.

Optional Feature:
- Macro MEM_DBUS_PERF_EN.
- Defined: adds output perf_stall_cnt [31:0].
  - Increments every cycle stall=1.
  - Wraps at 2^32−1 → 0.
  - Reset to 0.
- Undefined: the port and counter are absent, with no other change.

Decomposition:
- Shared package: msize_t (MSIZE1/2/4), op_t load/store members, the dbus request/response structs, and the state enum.
- One sub-module, mem_load_align: a purely combinational function of (op, offset, raw word, rt_old) to rdata, so it can be unit-tested in isolation.

Test Plan:
- LW 0x1000, addr_ok+data_ok on the first ADDR cycle, dresp_data=0xDEADBEEF → stall for exactly 2 cycles, then rdata=0xDEADBEEF, dreq_size=MSIZE4.
- SB addr 0x2003, wdata=0x000000AB, strobe_in=4'b1000; addr_ok delayed 3 cycles, data_ok 2 cycles later → dreq stable throughout ADDR, dreq_data=0xAB000000, dreq_strobe=4'b1000, DONE after data_ok.
- LB addr 0x3001, data=0x00008000 → rdata=0xFFFFFF80; LBU at the same address → rdata=0x00000080.
- LWL addr 0x4001, data=0x11223344, rt_old=0xAABBCCDD → dreq_addr=0x4000, rdata=0x3344CCDD. LWR at the same address → rdata=0xAA112233.
- LW addr 0x5002 → exc_adel=1, no dreq_valid, stall=0. SH addr 0x5001 with strobe_in=0 → exc_ades=1.
- resetn pulsed low in DATA → state IDLE, outputs 0 immediately; with MEM_DBUS_PERF_EN, perf_stall_cnt=0 after reset.
